// File: rtl/trivium_encrypt.sv
// Trivium keystream generator: loads KEY/IV once after reset, warms up, then writes len keystream bits into OUT.
// Latency: load on edge 1, warm-up on edges 2..1153, z_k lands in OUT on edge 1154+k. No backpressure.
// Optional `done` output when TRIVIUM_DONE_EN is defined.
module trivium_encrypt #(
    parameter int WARMUP = 1152,
    parameter int MAXLEN = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [79:0]       KEY,
    input  logic [79:0]       IV,
    input  logic [11:0]       len,
    output logic [MAXLEN-1:0] OUT
`ifdef TRIVIUM_DONE_EN
    ,
    output logic              done
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WARM = 3'd2;
    localparam logic [2:0] ST_GEN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // State bits kept 1-based so the indices read like the cipher definition.
    logic [288:1]      s_q, s_d;
    logic [MAXLEN-1:0] out_q, out_d;
    logic [2:0]        fsm_q, fsm_d;
    logic [10:0]       warm_q, warm_d;
    logic [9:0]        idx_q, idx_d;
    logic [9:0]        len_q, len_d;

    logic              t1, t2, t3, z;
    logic              t1n, t2n, t3n;
    logic [288:1]      s_rnd;

    always_comb begin
        t1    = s_q[66] ^ s_q[93];
        t2    = s_q[162] ^ s_q[177];
        t3    = s_q[243] ^ s_q[288];
        z     = t1 ^ t2 ^ t3;
        t1n   = t1 ^ (s_q[91] & s_q[92]) ^ s_q[171];
        t2n   = t2 ^ (s_q[175] & s_q[176]) ^ s_q[264];
        t3n   = t3 ^ (s_q[286] & s_q[287]) ^ s_q[69];
        s_rnd = {s_q[287:178], t2n, s_q[176:94], t1n, s_q[92:1], t3n};
    end

    always_comb begin
        fsm_d  = fsm_q;
        s_d    = s_q;
        out_d  = out_q;
        warm_d = warm_q;
        idx_d  = idx_q;
        len_d  = len_q;
        case (fsm_q)
            ST_IDLE: begin
                s_d    = {3'b111, 108'd0, 4'd0, IV, 13'd0, KEY};
                len_d  = (len > 12'(MAXLEN)) ? 10'(MAXLEN) : len[9:0];
                warm_d = 11'd0;
                idx_d  = 10'd0;
                fsm_d  = ST_LOAD;
            end
            ST_LOAD: begin
                // First warm-up round happens on the edge leaving LOAD.
                s_d    = s_rnd;
                warm_d = 11'd1;
                fsm_d  = ST_WARM;
            end
            ST_WARM: begin
                s_d    = s_rnd;
                warm_d = warm_q + 11'd1;
                if (warm_q == 11'(WARMUP - 1)) begin
                    fsm_d = (len_q == 10'd0) ? ST_DONE : ST_GEN;
                end
            end
            ST_GEN: begin
                s_d                = s_rnd;
                out_d[idx_q[8:0]]  = z;
                idx_d              = idx_q + 10'd1;
                if ((idx_q + 10'd1) == len_q) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_d = ST_DONE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q  <= ST_IDLE;
            s_q    <= '0;
            out_q  <= '0;
            warm_q <= '0;
            idx_q  <= '0;
            len_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            s_q    <= s_d;
            out_q  <= out_d;
            warm_q <= warm_d;
            idx_q  <= idx_d;
            len_q  <= len_d;
        end
    end

    assign OUT = out_q;

`ifdef TRIVIUM_DONE_EN
    assign done = (fsm_q == ST_DONE);
`endif

endmodule

// File: tb/tb_trivium_encrypt.sv
// Bench for trivium_encrypt: bit-array cipher model, per-cycle OUT/done comparison, directed scenarios.
module tb_trivium_encrypt;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [79:0]  KEY = '0;
    logic [79:0]  IV  = '0;
    logic [11:0]  len = '0;
    logic [511:0] OUT;
`ifdef TRIVIUM_DONE_EN
    logic         done;
`endif

    trivium_encrypt dut (
        .clk   (clk),
        .reset (rst),
        .KEY   (KEY),
        .IV    (IV),
        .len   (len),
        .OUT   (OUT)
`ifdef TRIVIUM_DONE_EN
        ,
        .done  (done)
`endif
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           edge_cnt;
    bit           chk_en = 1'b0;
    bit           mst [1:288];
    logic [511:0] exp_ks;
    int           exp_len;
    logic [511:0] ks_first;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One cipher round on the model state; returns the keystream bit.
    function automatic bit model_step();
        bit a, b, c, zz;
        a  = mst[66] ^ mst[93];
        b  = mst[162] ^ mst[177];
        c  = mst[243] ^ mst[288];
        zz = a ^ b ^ c;
        a  = a ^ (mst[91] & mst[92]) ^ mst[171];
        b  = b ^ (mst[175] & mst[176]) ^ mst[264];
        c  = c ^ (mst[286] & mst[287]) ^ mst[69];
        for (int i = 288; i >= 2; i--) mst[i] = mst[i-1];
        mst[1]   = c;
        mst[94]  = a;
        mst[178] = b;
        return zz;
    endfunction

    function automatic int model_ones();
        int n = 0;
        for (int i = 1; i <= 288; i++) n += int'(mst[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 1; i <= 288; i++) mst[i] = 1'b0;
    endtask

    task automatic model_gen(input logic [79:0] k, input logic [79:0] v);
        model_clear();
        for (int i = 1; i <= 80; i++) begin
            mst[i]    = k[i-1];
            mst[93+i] = v[i-1];
        end
        mst[286] = 1'b1;
        mst[287] = 1'b1;
        mst[288] = 1'b1;
        for (int r = 0; r < 1152; r++) void'(model_step());
        for (int j = 0; j < 512; j++) exp_ks[j] = model_step();
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Expected OUT after edge e: the first min(e-1153, len) keystream bits, rest zero.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int nb;
            logic [511:0] m;
            nb = edge_cnt - 1153;
            if (nb < 0) nb = 0;
            if (nb > exp_len) nb = exp_len;
            m = '0;
            for (int i = 0; i < 512; i++) if (i < nb) m[i] = 1'b1;
            chk("out_cycle", OUT, exp_ks & m);
`ifdef TRIVIUM_DONE_EN
            chk("done_cycle", 512'(done),
                512'((exp_len == 0) ? (edge_cnt >= 1153) : (edge_cnt >= 1153 + exp_len)));
`endif
        end
    end

    task automatic start_case(input logic [79:0] k, input logic [79:0] v, input logic [11:0] l);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b0;
        KEY    = k;
        IV     = v;
        len    = l;
        model_gen(k, v);
        exp_len = (l > 12'd512) ? 512 : int'(l);
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit zb;

        // Pin the model round function with hand-worked single-bit states.
        model_clear();
        zb = model_step();
        chk("pin_zero_z", 512'(zb), 512'd0);
        chk("pin_zero_ones", 512'(model_ones()), 512'd0);

        model_clear();
        mst[66] = 1'b1;
        zb = model_step();
        chk("pin_s66_z", 512'(zb), 512'd1);
        chk("pin_s66_bits", 512'({mst[67], mst[94], mst[1]}), 512'b110);
        chk("pin_s66_ones", 512'(model_ones()), 512'd2);

        model_clear();
        mst[91] = 1'b1;
        mst[92] = 1'b1;
        zb = model_step();
        chk("pin_and1_z", 512'(zb), 512'd0);
        chk("pin_and1_bits", 512'({mst[92], mst[93], mst[94]}), 512'b111);
        chk("pin_and1_ones", 512'(model_ones()), 512'd3);

        model_clear();
        mst[69] = 1'b1;
        zb = model_step();
        chk("pin_s69_z", 512'(zb), 512'd0);
        chk("pin_s69_bits", 512'({mst[1], mst[70]}), 512'b11);

        model_clear();
        mst[162] = 1'b1;
        mst[243] = 1'b1;
        zb = model_step();
        chk("pin_t2t3_z", 512'(zb), 512'd0);
        chk("pin_t2t3_bits", 512'({mst[1], mst[178], mst[163], mst[244]}), 512'b1111);

        // Reset state before any run.
        #12;
        chk("reset_out", OUT, 512'd0);
        chk("reset_state", 512'(dut.s_q), 512'd0);

        // Case 1: KEY=0, IV MSB set, full length, held well past completion.
        start_case(80'h0, 80'h80000000000000000000, 12'd512);
        ks_first = exp_ks;
        run_edges(2000);
        chk("case1_final", OUT, ks_first);

        // Case 2: all-zero key/IV, check the loaded state right after LOAD.
        start_case(80'h0, 80'h0, 12'd512);
        @(posedge clk);
        #1;
        chk("load_state", 512'(dut.s_q), 512'({3'b111, 285'd0}));
        chk("load_out", OUT, 512'd0);
        run_edges(1700);

        // Case 3: short request, upper OUT bits must stay zero.
        start_case(80'hA5A5_1234_5678_9ABC_DEF0, 80'h0F0F_F0F0_1357_2468_ACE1, 12'd16);
        run_edges(1300);
        chk("len16_low", 512'(OUT[15:0]), 512'(exp_ks[15:0]));
        chk("len16_high", 512'(OUT[511:16]), 512'd0);

        // Case 4: zero length produces nothing.
        start_case(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h1111_2222_3333_4444_5555, 12'd0);
        run_edges(2000);
        chk("len0_out", OUT, 512'd0);

        // Case 5: oversize length clamps to a full 512-bit run.
        start_case(80'h0, 80'h80000000000000000000, 12'hFFF);
        run_edges(1700);
        chk("clamp_eq_512", OUT, ks_first);

        // Case 6: async reset in the middle of generation, then a new key.
        start_case(80'h0, 80'h80000000000000000000, 12'd512);
        run_edges(1299);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("async_clr_out", OUT, 512'd0);
        chk("async_clr_state", 512'(dut.s_q), 512'd0);
        start_case(80'h0123456789ABCDEF0123, 80'h3C3C_0000_FFFF_1234_8001, 12'd512);
        run_edges(3);
        KEY = 80'hDEAD_BEEF_0000_1111_2222;
        IV  = 80'h0;
        len = 12'd5;
        run_edges(1700);
        chk("newkey_final", OUT, exp_ks);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trivium_encrypt.md
Name: trivium_encrypt

Overview:
- Trivium stream-cipher keystream generator (eSTREAM, 80-bit key, 80-bit IV, 288-bit state), one keystream bit per clock.
- After reset release it loads KEY/IV once, runs the 1152-round warm-up, then produces `len` keystream bits into a 512-bit output register.
- The keystream is XORed with plaintext by downstream logic.

Parameters:
- WARMUP, 1152, initialisation rounds (4 x 288) before keystream output.
- MAXLEN, 512, width of OUT and upper bound on keystream bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- KEY  input  80  secret key, sampled in LOAD only.
- IV  input  80  initial value, sampled in LOAD only.
- len  input  12  number of keystream bits requested, sampled in LOAD; values >512 are clamped to 512.
- OUT  output  512  keystream register; OUT[k] holds keystream bit z_k.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset=1: state=IDLE, s[1..288]=0, OUT=0, counters=0.
- FSM states: IDLE -> LOAD -> WARM -> GEN -> DONE.
  - IDLE -> LOAD: on the first rising edge with reset=0.
  - LOAD (1 cycle) loads the state:
    - s[i]=KEY[i-1] for i=1..80; s[81..93]=0.
    - s[93+i]=IV[i-1] for i=1..80; s[174..177]=0.
    - s[178..285]=0; s[286..288]=1.
    - Latches len_q = min(len,512).
  - WARM: exactly 1152 cycles of the update function; OUT stays 0; 11-bit counter.
  - GEN: one round per cycle; bit z_k is written to OUT[k], k=0..len_q-1 (10-bit index).
    - After len_q bits -> DONE. If len_q=0, go directly WARM -> DONE.
  - DONE: state frozen; OUT held; stays until reset.
- Round function, with s indices 1-based:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1'=t1^(s91&s92)^s171; t2'=t2^(s175&s176)^s264; t3'=t3^(s286&s287)^s69.
  - s[1..93]<={t3',s[1..92]}; s[94..177]<={t1',s[94..176]}; s[178..288]<={t2',s[178..287]}.
- Latency:
  - Edge 1 after reset release = LOAD; edges 2..1153 = WARM.
  - z_k is visible on OUT after edge 1154+k.
  - len=512: complete after edge 1665.
- OUT bits with index >= len_q remain 0. No bit is ever written twice.
- Changes on KEY/IV/len after LOAD are ignored until the next reset.
- Reset mid-WARM or mid-GEN: immediate clear of OUT and state. A new run starts on release.
- Reset held several cycles: identical to a single-cycle reset.

Optional Feature:
- Macro TRIVIUM_DONE_EN.
- Defined: adds output port `done` (1 bit, after OUT).
  - done=0 in reset and in all states except DONE.
  - done=1 in DONE, first set on the same edge that writes the last bit (or on leaving WARM when len_q=0).
  - Held until reset.
- Undefined: no done port; port list is exactly clk, reset, KEY, IV, len, OUT. Internal behaviour is identical.

Test Plan:
- KEY=0, IV=80'h80000000000000000000, len=512, reset 2 cycles then release:
  - OUT==0 through edge 1153.
  - OUT[0] matches the bit-accurate reference model at edge 1154.
  - Full 512-bit OUT equals the model at edge 1665 and is unchanged at edge 2000.
- KEY=0, IV=0, len=512: probe state after LOAD -> s[286..288]=3'b111, all other bits 0. OUT equals model after 1665 edges.
- len=16, any KEY/IV -> OUT[15:0] equals model bits z0..z15 after edge 1169; OUT[511:16]==0 forever.
- len=0 -> OUT stays 0 for 2000 cycles. With TRIVIUM_DONE_EN, done=1 after edge 1153.
- len=12'hFFF -> clamped: 512 bits produced, identical to the len=512 result.
- Assert reset at edge 1300 during GEN -> OUT=0 immediately (asynchronous). After release with different KEY=80'h0123456789ABCDEF0123, OUT equals the model for the new key; KEY changes after LOAD have no effect.
